// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared state encodings and control codes for the divider
//
// Purpose: common definitions used by div_unit and by the EX stage that drives it.
//   div_state_e        : divider FSM states (DivFree, DivByZero, DivOn, DivEnd)
//   DivStart/DivStop   : levels of the EX start request
//   DivResultReady/... : levels of the divider ready flag
//   EXE_DIV_OP/DIVU_OP : aluop codes EX decodes to select signed_div_i
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU
//
// Purpose: computes {remainder, quotient} one quotient bit per clock; EX holds
// start_i high and stalls until ready_o, then drops start_i to release the unit.
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   signed_div_i : 1 = two's-complement DIV, 0 = DIVU
//   opdata1_i    : dividend (captured on the accepting edge)
//   opdata2_i    : divisor  (captured on the accepting edge)
//   start_i      : division request, held until the result is consumed
//   annul_i      : pipeline flush, cancels a division in BY_ZERO or ON
//   result_o     : {remainder, quotient}, zero unless ready_o
//   ready_o      : result_o valid
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  div_state_e            state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  // {partial remainder, dividend/quotient}; the dividend shifts out of the low
  // half as quotient bits shift in, leaving the remainder in the upper half.
  logic [2*DATA_W:0]     work, work_n;
  logic [DATA_W-1:0]     divisor, divisor_n;
  logic                  q_neg, q_neg_n;
  logic                  r_neg, r_neg_n;
  logic [2*DATA_W-1:0]   result_n;
  logic                  ready_n;

  // Operand magnitudes; DIVU passes operands through untouched.
  logic                  op1_neg, op2_neg;
  logic [DATA_W-1:0]     op1_abs, op2_abs;

  assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
  assign op1_abs = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
  assign op2_abs = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

  // One restoring step. The shifted remainder is kept one bit wider than the
  // divisor so 2*rem never overflows; the extra top bit of the difference is
  // the borrow that decides the quotient bit.
  logic [DATA_W+1:0]     rem_shift;
  logic [DATA_W+1:0]     trial;
  logic                  fits;
  logic [2*DATA_W:0]     work_step;

  assign rem_shift = work[2*DATA_W:DATA_W-1];
  assign trial     = rem_shift - {2'b00, divisor};
  assign fits      = ~trial[DATA_W+1];
  assign work_step = fits ? {trial[DATA_W:0],     work[DATA_W-2:0], 1'b1}
                          : {rem_shift[DATA_W:0], work[DATA_W-2:0], 1'b0};

  // Sign correction applied once, on the completing edge.
  logic [DATA_W-1:0]     quo_mag, rem_mag, quo_fix, rem_fix;

  assign quo_mag = work[DATA_W-1:0];
  assign rem_mag = work[2*DATA_W-1:DATA_W];
  assign quo_fix = q_neg ? (~quo_mag + 1'b1) : quo_mag;
  assign rem_fix = r_neg ? (~rem_mag + 1'b1) : rem_mag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DivFree;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      work     <= work_n;
      divisor  <= divisor_n;
      q_neg    <= q_neg_n;
      r_neg    <= r_neg_n;
      result_o <= result_n;
      ready_o  <= ready_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    work_n    = work;
    divisor_n = divisor;
    q_neg_n   = q_neg;
    r_neg_n   = r_neg;
    result_n  = result_o;
    ready_n   = ready_o;

    case (state)
      DivFree: begin
        result_n = '0;
        ready_n  = DivResultNotReady;
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_n = DivByZero;
          end else begin
            state_n   = DivOn;
            cnt_n     = '0;
            work_n    = {{(DATA_W+1){1'b0}}, op1_abs};
            divisor_n = op2_abs;
            q_neg_n   = op1_neg ^ op2_neg;
            r_neg_n   = op1_neg;
          end
        end
      end

      DivByZero: begin
        if (annul_i) begin
          state_n  = DivFree;
          cnt_n    = '0;
          result_n = '0;
          ready_n  = DivResultNotReady;
        end else begin
          state_n  = DivEnd;
          result_n = '0;
          ready_n  = DivResultReady;
        end
      end

      DivOn: begin
        // Flush wins over both iteration and completion.
        if (annul_i) begin
          state_n  = DivFree;
          cnt_n    = '0;
          result_n = '0;
          ready_n  = DivResultNotReady;
        end else if (cnt != CNT_W'(DATA_W)) begin
          work_n = work_step;
          cnt_n  = cnt + 1'b1;
        end else begin
          state_n  = DivEnd;
          cnt_n    = '0;
          result_n = {rem_fix, quo_fix};
          ready_n  = DivResultReady;
        end
      end

      DivEnd: begin
        // Result is committed here, so annul_i is deliberately ignored.
        if (start_i == DivStop) begin
          state_n  = DivFree;
          result_n = '0;
          ready_n  = DivResultNotReady;
        end
      end

      default: begin
        state_n  = DivFree;
        cnt_n    = '0;
        result_n = '0;
        ready_n  = DivResultNotReady;
      end
    endcase
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int errors = 0;
  int checks = 0;

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a request, then count edges after the capture edge until ready (bounded).
  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output logic [63:0] res);
    @(negedge clk);
    signed_div = sg; op1 = a; op2 = b; start = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (ready) break;
    end
    res = result;
  endtask

  task automatic release_req();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL idle_ready got=%b exp=0", ready); end
  endtask

  task automatic test_divu_basic();
    int c; logic [63:0] r;
    run_div(1'b0, 32'd100, 32'd7, c, r);
    checks++; if (c !== 33) begin errors++; $display("FAIL divu_latency got=%0d exp=33", c); end
    checks++; if (r !== {32'h2, 32'hE}) begin errors++; $display("FAIL divu_100_7 got=%h exp=%h", r, {32'h2, 32'hE}); end
    // Hold in END with start high and a flush pulse: result must stay put.
    @(negedge clk); annul = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); annul = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL end_hold_ready got=%b exp=1", ready); end
    checks++; if (result !== {32'h2, 32'hE}) begin errors++; $display("FAIL end_hold_result got=%h exp=%h", result, {32'h2, 32'hE}); end
    release_req();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL release_ready got=%b exp=0", ready); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL release_result got=%h exp=0", result); end
  endtask

  task automatic test_signed();
    int c; logic [63:0] r;
    run_div(1'b1, 32'hFFFFFFFB, 32'h6, c, r);
    checks++; if (r !== {32'hFFFFFFFB, 32'h0}) begin errors++; $display("FAIL div_m5_6 got=%h exp=%h", r, {32'hFFFFFFFB, 32'h0}); end
    release_req();
    run_div(1'b1, 32'hFFFFFFFB, 32'h2, c, r);
    checks++; if (c !== 33) begin errors++; $display("FAIL div_latency got=%0d exp=33", c); end
    checks++; if (r !== {32'hFFFFFFFF, 32'hFFFFFFFE}) begin errors++; $display("FAIL div_m5_2 got=%h exp=%h", r, {32'hFFFFFFFF, 32'hFFFFFFFE}); end
    release_req();
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, c, r);
    checks++; if (r !== {32'h1, 32'hFFFFFFFD}) begin errors++; $display("FAIL div_7_m2 got=%h exp=%h", r, {32'h1, 32'hFFFFFFFD}); end
    release_req();
    run_div(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, c, r);
    checks++; if (r !== {32'hFFFFFFFF, 32'h3}) begin errors++; $display("FAIL div_m7_m2 got=%h exp=%h", r, {32'hFFFFFFFF, 32'h3}); end
    release_req();
  endtask

  task automatic test_boundaries();
    int c; logic [63:0] r;
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, c, r);
    checks++; if (r !== {32'h0, 32'h80000000}) begin errors++; $display("FAIL div_overflow got=%h exp=%h", r, {32'h0, 32'h80000000}); end
    release_req();
    run_div(1'b0, 32'hFFFFFFFF, 32'h1, c, r);
    checks++; if (r !== {32'h0, 32'hFFFFFFFF}) begin errors++; $display("FAIL divu_max_1 got=%h exp=%h", r, {32'h0, 32'hFFFFFFFF}); end
    release_req();
    run_div(1'b0, 32'hFFFFFFFB, 32'h6, c, r);
    checks++; if (r !== {32'h5, 32'h2AAAAAA9}) begin errors++; $display("FAIL divu_big_6 got=%h exp=%h", r, {32'h5, 32'h2AAAAAA9}); end
    release_req();
  endtask

  task automatic test_div_by_zero();
    int c; logic [63:0] r;
    run_div(1'b1, 32'h12345678, 32'h0, c, r);
    checks++; if (c !== 1) begin errors++; $display("FAIL byzero_latency got=%0d exp=1", c); end
    checks++; if (r !== 64'h0) begin errors++; $display("FAIL byzero_result got=%h exp=0", r); end
    release_req();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL byzero_release got=%b exp=0", ready); end
  endtask

  task automatic test_annul();
    int c; logic [63:0] r;
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk); annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL annul_ready got=%b exp=0", ready); end
    @(negedge clk); annul = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL annul_no_finish got=%b exp=0", ready); end
    run_div(1'b0, 32'd100, 32'd7, c, r);
    checks++; if (c !== 33) begin errors++; $display("FAIL post_annul_latency got=%0d exp=33", c); end
    checks++; if (r !== {32'h2, 32'hE}) begin errors++; $display("FAIL post_annul_result got=%h exp=%h", r, {32'h2, 32'hE}); end
    release_req();
  endtask

  task automatic test_operand_change();
    int c;
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd9; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    signed_div = 1'b1; op1 = 32'hDEADBEEF; op2 = 32'h3;
    c = 0;
    while (c < 100) begin
      @(posedge clk); #1;
      c++;
      if (ready) break;
    end
    checks++; if (c !== 33) begin errors++; $display("FAIL opchg_latency got=%0d exp=33", c); end
    checks++; if (result !== {32'h1, 32'd111}) begin errors++; $display("FAIL opchg_result got=%h exp=%h", result, {32'h1, 32'd111}); end
    release_req();
  endtask

  task automatic test_reset_mid();
    int c; logic [63:0] r;
    // Reset while a committed result is visible: outputs clear without an edge.
    run_div(1'b0, 32'd50, 32'd8, c, r);
    checks++; if (r !== {32'h2, 32'h6}) begin errors++; $display("FAIL pre_reset_result got=%h exp=%h", r, {32'h2, 32'h6}); end
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL async_reset_ready got=%b exp=0", ready); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL async_reset_result got=%h exp=0", result); end
    start = 1'b0;
    @(negedge clk); rst = 1'b1;
    // Reset in the middle of ON: division is abandoned.
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(posedge clk);
    repeat (15) @(posedge clk);
    #2; rst = 1'b0; start = 1'b0;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got=%b exp=0", ready); end
    @(negedge clk); rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_reset_idle got=%b exp=0", ready); end
    run_div(1'b1, 32'hFFFFFF9C, 32'd7, c, r);
    checks++; if (r !== {32'hFFFFFFFE, 32'hFFFFFFF2}) begin errors++; $display("FAIL post_reset_result got=%h exp=%h", r, {32'hFFFFFFFE, 32'hFFFFFFF2}); end
    release_req();
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_boundaries();
    test_div_by_zero();
    test_annul();
    test_operand_change();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
